// File: rtl/axis_fifo_status_if.sv
// AXI4-Stream bundle used on both sides of axis_fifo_status.
// The master drives payload and tvalid; the slave drives tready.
interface axis_fifo_status_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_fifo_status.sv
// AXI4-Stream FIFO with frame mode, oversize-frame drop and occupancy/threshold status.
// Optional AXIS_FIFO_PAUSE_EN adds pause_req/pause_ack to halt the output at frame boundaries.
module axis_fifo_status #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter bit KEEP_ENABLE    = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter bit LAST_ENABLE    = 1'b1,
    parameter bit ID_ENABLE      = 1'b0,
    parameter int ID_WIDTH       = 8,
    parameter bit DEST_ENABLE    = 1'b0,
    parameter int DEST_WIDTH     = 8,
    parameter bit USER_ENABLE    = 1'b1,
    parameter int USER_WIDTH     = 1,
    parameter bit FRAME_FIFO     = 1'b1,
    parameter bit DROP_WHEN_FULL = 1'b0,
    parameter bit DROP_BAD_FRAME = 1'b0,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_fifo_status_if.slave     s_axis,
    axis_fifo_status_if.master    m_axis,
    input  logic [ADDR_WIDTH:0]   cfg_almost_full_thresh,
    input  logic [ADDR_WIDTH:0]   cfg_almost_empty_thresh,
`ifdef AXIS_FIFO_PAUSE_EN
    input  logic                  pause_req,
    output logic                  pause_ack,
`endif
    output logic [ADDR_WIDTH:0]   status_depth,
    output logic [ADDR_WIDTH:0]   status_frame_count,
    output logic                  status_almost_full,
    output logic                  status_almost_empty,
    output logic                  status_overflow,
    output logic                  status_bad_frame,
    output logic                  status_good_frame
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    beat_t ram [DEPTH];
    beat_t in_beat, mem_beat, out_beat;

    ptr_t wr_ptr, wr_ptr_cur, rd_ptr, depth_now;
    logic drop_frame;
    logic [1:0] vld_pipe;  // [0] RAM read register, [1] output register
    logic full, full_cur, full_wr, empty;
    logic s_ready, s_xfer, drop_beat, bad_last, commit;
    logic m_xfer, out_load, rd_en, rd_last, hold;

    function automatic logic wrapped(input ptr_t a, input ptr_t b);
        return (a[ADDR_WIDTH] != b[ADDR_WIDTH]) && (a[ADDR_WIDTH-1:0] == b[ADDR_WIDTH-1:0]);
    endfunction

    assign full      = wrapped(wr_ptr, rd_ptr);
    assign full_cur  = wrapped(wr_ptr_cur, rd_ptr);
    assign full_wr   = wrapped(wr_ptr_cur, wr_ptr);  // current frame alone fills the RAM
    assign empty     = (wr_ptr == rd_ptr);
    assign depth_now = wr_ptr - rd_ptr;

    assign in_beat = '{data: s_axis.tdata,
                       keep: s_axis.tkeep,
                       last: LAST_ENABLE ? s_axis.tlast : 1'b1,
                       id:   s_axis.tid,
                       dest: s_axis.tdest,
                       user: s_axis.tuser};

    // Oversize frames must be swallowed, otherwise backpressure would never release
    always_comb begin
        s_ready = 1'b1;
        if (!FRAME_FIFO)
            s_ready = !full;
        else if (!DROP_WHEN_FULL)
            s_ready = !full_cur || full_wr || drop_frame;
    end

    assign s_axis.tready = s_ready;
    assign s_xfer    = s_axis.tvalid && s_ready;
    assign drop_beat = drop_frame || full_wr || (DROP_WHEN_FULL && full_cur);
    assign bad_last  = DROP_BAD_FRAME && USER_ENABLE && in_beat.last &&
                       ((s_axis.tuser & USER_BAD_FRAME_MASK) == (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));
    assign commit    = s_xfer && in_beat.last && (!FRAME_FIFO || !(drop_beat || bad_last));

    assign m_xfer   = vld_pipe[1] && m_axis.tready;
    assign out_load = (!vld_pipe[1] || m_xfer) && vld_pipe[0] && !hold;
    assign rd_en    = (!vld_pipe[0] || out_load) && !empty;
    assign rd_last  = ram[rd_ptr[ADDR_WIDTH-1:0]].last;

`ifdef AXIS_FIFO_PAUSE_EN
    logic out_mid;  // output register holds a beat of an unfinished frame

    always_ff @(posedge clk) begin
        if (rst)
            out_mid <= 1'b0;
        else if (out_load)
            out_mid <= !mem_beat.last;
    end

    assign hold      = pause_req && !out_mid;
    assign pause_ack = hold && !vld_pipe[1];
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (s_xfer && (!FRAME_FIFO || !drop_beat))
            ram[wr_ptr_cur[ADDR_WIDTH-1:0]] <= in_beat;
        if (rd_en)
            mem_beat <= ram[rd_ptr[ADDR_WIDTH-1:0]];
        if (out_load)
            out_beat <= mem_beat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr            <= '0;
            wr_ptr_cur        <= '0;
            drop_frame        <= 1'b0;
            status_good_frame <= 1'b0;
            status_bad_frame  <= 1'b0;
            status_overflow   <= 1'b0;
        end else begin
            if (s_xfer) begin
                if (FRAME_FIFO && drop_beat) begin
                    drop_frame <= !in_beat.last;
                    if (in_beat.last)
                        wr_ptr_cur <= wr_ptr;
                end else if (FRAME_FIFO && bad_last) begin
                    wr_ptr_cur <= wr_ptr;
                end else begin
                    wr_ptr_cur <= wr_ptr_cur + PTR_ONE;
                    if (!FRAME_FIFO || in_beat.last)
                        wr_ptr <= wr_ptr_cur + PTR_ONE;
                end
            end
            status_good_frame <= commit;
            status_bad_frame  <= FRAME_FIFO && s_xfer && !drop_beat && bad_last;
            status_overflow   <= FRAME_FIFO && s_xfer && drop_beat && in_beat.last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr              <= '0;
            vld_pipe            <= '0;
            status_depth        <= '0;
            status_frame_count  <= '0;
            status_almost_full  <= 1'b0;
            status_almost_empty <= 1'b1;
        end else begin
            if (rd_en) begin
                rd_ptr      <= rd_ptr + PTR_ONE;
                vld_pipe[0] <= 1'b1;
            end else if (out_load) begin
                vld_pipe[0] <= 1'b0;
            end
            if (out_load)
                vld_pipe[1] <= 1'b1;
            else if (m_xfer)
                vld_pipe[1] <= 1'b0;

            status_depth        <= depth_now;
            status_almost_full  <= (depth_now >= cfg_almost_full_thresh);
            status_almost_empty <= (depth_now <= cfg_almost_empty_thresh);

            case ({commit, rd_en && rd_last})
                2'b10:   status_frame_count <= status_frame_count + PTR_ONE;
                2'b01:   status_frame_count <= status_frame_count - PTR_ONE;
                default: status_frame_count <= status_frame_count;
            endcase
        end
    end

    assign m_axis.tvalid = vld_pipe[1];
    assign m_axis.tdata  = out_beat.data;
    assign m_axis.tkeep  = KEEP_ENABLE ? out_beat.keep : '1;
    assign m_axis.tlast  = LAST_ENABLE ? out_beat.last : 1'b1;
    assign m_axis.tid    = ID_ENABLE   ? out_beat.id   : '0;
    assign m_axis.tdest  = DEST_ENABLE ? out_beat.dest : '0;
    assign m_axis.tuser  = USER_ENABLE ? out_beat.user : '0;
endmodule
